// File: rtl/uart_cmd_parser.sv
// ASCII command parser for UART bytes: "F<digits>\r" sets the tuning frequency, "G<digits>\r" sets the gain.
// Malformed or stalled commands are rejected with a single-cycle o_Err pulse.
module uart_cmd_parser #(
  parameter logic [31:0] RESET_FREQ   = 32'd7074000,
  parameter logic [7:0]  RESET_GAIN   = 8'd128,
  parameter int          TIMEOUT_CLKS = 13600000
) (
  input  logic        osc_clk,
  input  logic        i_Rst_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [31:0] o_Freq,
  output logic        o_Freq_Valid,
  output logic [7:0]  o_Gain,
  output logic        o_Gain_Valid,
  output logic        o_Err
);
  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_F_DIG   = 2'd1;
  localparam logic [1:0]  S_G_DIG   = 2'd2;
  localparam logic [1:0]  S_DISCARD = 2'd3;
  localparam logic [7:0]  C_CR      = 8'h0D;
  localparam logic [7:0]  C_LF      = 8'h0A;
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CLKS - 1);

  logic [1:0]  r_state;
  logic [35:0] r_acc;
  logic [3:0]  r_dcnt;
  logic [31:0] r_tmo;
  logic        r_dv_prev;
  logic        r_dv_armed;
  logic        r_load_f;
  logic        r_load_g;

  logic        w_evt;
  logic        w_is_digit;
  logic        w_is_f;
  logic        w_over;
  logic        w_tmo_hit;
  logic [35:0] w_acc_upd;
  logic [1:0]  w_state_nxt;
  logic [35:0] w_acc_nxt;
  logic [3:0]  w_dcnt_nxt;
  logic [31:0] w_tmo_nxt;
  logic        w_err;
  logic        w_load_f;
  logic        w_load_g;

  // A DV level still high when reset releases must drop once before it can count as an edge.
  assign w_evt      = i_Rx_DV & ~r_dv_prev & r_dv_armed;
  assign w_is_digit = (i_Rx_Byte >= 8'h30) && (i_Rx_Byte <= 8'h39);
  assign w_acc_upd  = (r_acc * 36'd10) + {32'd0, i_Rx_Byte[3:0]};
  assign w_is_f     = (r_state == S_F_DIG);
  assign w_over     = w_is_f ? ((r_dcnt == 4'd10) || (w_acc_upd > 36'h0_FFFF_FFFF))
                             : ((r_dcnt == 4'd3)  || (w_acc_upd > 36'd255));
  assign w_tmo_hit  = (r_tmo == TMO_LAST);
  assign w_tmo_nxt  = (w_evt || (w_state_nxt == S_IDLE)) ? 32'd0 : (r_tmo + 32'd1);

  // Next-state, accumulator and pulse decode; a byte event takes priority over timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_dcnt_nxt  = r_dcnt;
    w_err       = 1'b0;
    w_load_f    = 1'b0;
    w_load_g    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_evt) begin
          case (i_Rx_Byte)
            8'h46, 8'h66: begin
              w_state_nxt = S_F_DIG;
              w_acc_nxt   = 36'd0;
              w_dcnt_nxt  = 4'd0;
            end
            8'h47, 8'h67: begin
              w_state_nxt = S_G_DIG;
              w_acc_nxt   = 36'd0;
              w_dcnt_nxt  = 4'd0;
            end
            C_CR, C_LF: w_state_nxt = S_IDLE;
            default: begin
              w_err       = 1'b1;
              w_state_nxt = S_DISCARD;
            end
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_F_DIG, S_G_DIG: begin
        if (w_evt) begin
          if (w_is_digit) begin
            if (w_over) begin
              w_err       = 1'b1;
              w_state_nxt = S_DISCARD;
            end else begin
              w_acc_nxt  = w_acc_upd;
              w_dcnt_nxt = r_dcnt + 4'd1;
            end
          end else if (i_Rx_Byte == C_CR) begin
            if (r_dcnt == 4'd0) begin
              w_err = 1'b1;
            end else begin
              w_load_f = w_is_f;
              w_load_g = ~w_is_f;
            end
            w_state_nxt = S_IDLE;
          end else if (i_Rx_Byte == C_LF) begin
            w_state_nxt = r_state;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_DISCARD;
          end
        end else if (w_tmo_hit) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_DISCARD: begin
        if (w_evt) begin
          w_state_nxt = (i_Rx_Byte == C_CR) ? S_IDLE : S_DISCARD;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DISCARD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Parser state, accumulator, inter-byte timer and DV edge tracking.
  always_ff @(posedge osc_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state    <= S_IDLE;
      r_acc      <= 36'd0;
      r_dcnt     <= 4'd0;
      r_tmo      <= 32'd0;
      r_dv_prev  <= 1'b0;
      r_dv_armed <= 1'b0;
      r_load_f   <= 1'b0;
      r_load_g   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_tmo      <= w_tmo_nxt;
      r_dv_prev  <= i_Rx_DV;
      r_dv_armed <= r_dv_armed | ~i_Rx_DV;
      r_load_f   <= w_load_f;
      r_load_g   <= w_load_g;
    end
  end

  // Registered outputs; the accepted value lands one cycle after the terminating CR.
  always_ff @(posedge osc_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Freq       <= RESET_FREQ;
      o_Gain       <= RESET_GAIN;
      o_Freq_Valid <= 1'b0;
      o_Gain_Valid <= 1'b0;
      o_Err        <= 1'b0;
    end else begin
      o_Err        <= w_err;
      o_Freq_Valid <= r_load_f;
      o_Gain_Valid <= r_load_g;
      o_Freq       <= r_load_f ? r_acc[31:0] : o_Freq;
      o_Gain       <= r_load_g ? r_acc[7:0]  : o_Gain;
    end
  end

endmodule
